// File: rtl/stream_src_pkg.sv
// stream_src_pkg: shared types and widths for the sequence source.
//   DATA_W / CNT_W : element width and element-count width
//   state_t        : IDLE -> EMIT -> EOS -> DONE control states
//   elem_t         : one out0 beat (field0 = value, field1 = EOS flag)
//   EOS_BEAT       : the terminating beat (value 0, flag 1)
package stream_src_pkg;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned CNT_W  = 32;

   typedef enum logic [1:0] {
      IDLE,
      EMIT,
      EOS,
      DONE
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] field0;
      logic              field1;
   } elem_t;

   localparam elem_t EOS_BEAT = '{field0: '0, field1: 1'b1};

endpackage

// File: rtl/stream_seq_source_if.sv
// stream_seq_source_if: the three handshake channels of the sequence source.
//   inCtrl  : start token with cfg_start / cfg_step / cfg_count
//   out0    : element stream (out0_data_field0 value, out0_data_field1 EOS flag)
//   outCtrl : completion token
// master = the source itself, slave = its environment.
interface stream_seq_source_if #(
   parameter int unsigned DATA_W = stream_src_pkg::DATA_W,
   parameter int unsigned CNT_W  = stream_src_pkg::CNT_W
) ();

   logic              inCtrl_valid;
   logic              inCtrl_ready;
   logic [DATA_W-1:0] cfg_start;
   logic [DATA_W-1:0] cfg_step;
   logic [CNT_W-1:0]  cfg_count;

   logic              out0_valid;
   logic              out0_ready;
   logic [DATA_W-1:0] out0_data_field0;
   logic              out0_data_field1;

   logic              outCtrl_valid;
   logic              outCtrl_ready;

   modport master (
      input  inCtrl_valid, cfg_start, cfg_step, cfg_count, out0_ready, outCtrl_ready,
      output inCtrl_ready, out0_valid, out0_data_field0, out0_data_field1, outCtrl_valid
   );

   modport slave (
      output inCtrl_valid, cfg_start, cfg_step, cfg_count, out0_ready, outCtrl_ready,
      input  inCtrl_ready, out0_valid, out0_data_field0, out0_data_field1, outCtrl_valid
   );

endinterface

// File: rtl/stream_src_fsm.sv
// stream_src_fsm: control state and remaining-element counter.
//   clock, reset : single clock, synchronous active-high reset
//   in_fire      : start token transferred (cfg_count sampled)
//   out_fire     : out0 beat transferred
//   ctrl_fire    : completion token transferred
//   cfg_count    : number of data elements before EOS
//   state        : current control state
module stream_src_fsm
   import stream_src_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             in_fire,
   input  logic             out_fire,
   input  logic             ctrl_fire,
   input  logic [CNT_W-1:0] cfg_count,
   output state_t           state
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] remain_q, remain_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         remain_q <= '0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      unique case (state_q)
         IDLE: begin
            if (in_fire) begin
               remain_d = cfg_count;
               state_d  = (cfg_count != '0) ? EMIT : EOS;
            end
         end
         EMIT: begin
            // Leave on the beat that consumes the last element, so remain
            // only ever counts down to zero and cannot wrap.
            if (out_fire) begin
               remain_d = remain_q - CNT_W'(1);
               if (remain_q == CNT_W'(1)) state_d = EOS;
            end
         end
         EOS: begin
            if (out_fire) state_d = DONE;
         end
         DONE: begin
            if (ctrl_fire) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign state = state_q;

endmodule

// File: rtl/stream_seq_source.sv
// stream_seq_source: on one start token emits cfg_count elements
// cfg_start, cfg_start+cfg_step, ... (mod 2^DATA_W) on out0, then an EOS beat,
// then offers a completion token on outCtrl.
//   clock, reset : single clock, synchronous active-high reset
//   bus          : inCtrl / out0 / outCtrl channels (master side)
// All valids and data come from registered state only; readies never feed a
// valid combinationally. Every output is held at 0 while reset is high.
module stream_seq_source
   import stream_src_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   stream_seq_source_if.master  bus
);

   state_t            state;
   logic [DATA_W-1:0] cur_q, cur_d;
   logic [DATA_W-1:0] step_q, step_d;
   elem_t             beat;
   logic              in_ready, out_valid, ctrl_valid;
   logic              in_fire, out_fire, ctrl_fire;

   always_comb begin
      in_ready   = !reset && (state == IDLE);
      out_valid  = !reset && ((state == EMIT) || (state == EOS));
      ctrl_valid = !reset && (state == DONE);
      in_fire    = in_ready   && bus.inCtrl_valid;
      out_fire   = out_valid  && bus.out0_ready;
      ctrl_fire  = ctrl_valid && bus.outCtrl_ready;
   end

   stream_src_fsm u_fsm (
      .clock     (clock),
      .reset     (reset),
      .in_fire   (in_fire),
      .out_fire  (out_fire),
      .ctrl_fire (ctrl_fire),
      .cfg_count (bus.cfg_count),
      .state     (state)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         cur_q  <= '0;
         step_q <= '0;
      end else begin
         cur_q  <= cur_d;
         step_q <= step_d;
      end
   end

   always_comb begin
      cur_d  = cur_q;
      step_d = step_q;
      if (in_fire) begin
         cur_d  = bus.cfg_start;
         step_d = bus.cfg_step;
      end else if (out_fire && (state == EMIT)) begin
         cur_d = cur_q + step_q;
      end
   end

   always_comb begin
      beat = '0;
      if (!reset) begin
         if (state == EMIT)     beat = '{field0: cur_q, field1: 1'b0};
         else if (state == EOS) beat = EOS_BEAT;
      end
   end

   assign bus.inCtrl_ready     = in_ready;
   assign bus.out0_valid       = out_valid;
   assign bus.out0_data_field0 = beat.field0;
   assign bus.out0_data_field1 = beat.field1;
   assign bus.outCtrl_valid    = ctrl_valid;

endmodule

// File: tb/tb_stream_seq_source.sv
// tb_stream_seq_source: directed bench for stream_seq_source. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_stream_seq_source;

   logic clk = 1'b0;
   logic rst;
   int unsigned checks = 0;
   int unsigned failures = 0;

   always #5 clk = ~clk;

   stream_seq_source_if bus ();

   stream_seq_source dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic exp_beat(input string tag, input logic [63:0] val);
      chk({tag, "_valid"}, 64'(bus.out0_valid), 64'd1);
      chk({tag, "_data"},  bus.out0_data_field0, val);
      chk({tag, "_eos"},   64'(bus.out0_data_field1), 64'd0);
   endtask

   task automatic exp_eos(input string tag);
      chk({tag, "_valid"}, 64'(bus.out0_valid), 64'd1);
      chk({tag, "_data"},  bus.out0_data_field0, 64'd0);
      chk({tag, "_eos"},   64'(bus.out0_data_field1), 64'd1);
   endtask

   task automatic exp_done(input string tag);
      chk({tag, "_ctrl"},  64'(bus.outCtrl_valid), 64'd1);
      chk({tag, "_out0"},  64'(bus.out0_valid), 64'd0);
      chk({tag, "_inrdy"}, 64'(bus.inCtrl_ready), 64'd0);
   endtask

   task automatic exp_idle(input string tag);
      chk({tag, "_inrdy"}, 64'(bus.inCtrl_ready), 64'd1);
      chk({tag, "_out0"},  64'(bus.out0_valid), 64'd0);
      chk({tag, "_ctrl"},  64'(bus.outCtrl_valid), 64'd0);
   endtask

   // Offers one start token in IDLE; returns on the falling edge after acceptance.
   task automatic start(input logic [63:0] s, input logic [63:0] st, input logic [31:0] c);
      bus.inCtrl_valid = 1'b1;
      bus.cfg_start    = s;
      bus.cfg_step     = st;
      bus.cfg_count    = c;
      tick();
      bus.inCtrl_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned idx;
      logic        r;

      rst               = 1'b1;
      bus.inCtrl_valid  = 1'b0;
      bus.cfg_start     = '0;
      bus.cfg_step      = '0;
      bus.cfg_count     = '0;
      bus.out0_ready    = 1'b1;
      bus.outCtrl_ready = 1'b1;
      tick();
      tick();
      chk("rst_inrdy", 64'(bus.inCtrl_ready), 64'd0);
      chk("rst_out0",  64'(bus.out0_valid), 64'd0);
      chk("rst_ctrl",  64'(bus.outCtrl_valid), 64'd0);
      chk("rst_data",  bus.out0_data_field0, 64'd0);
      rst = 1'b0;
      tick();
      exp_idle("t0_idle");

      // 1: start 5, step 3, count 4
      start(64'd5, 64'd3, 32'd4);
      exp_beat("t1_b0", 64'd5);  tick();
      exp_beat("t1_b1", 64'd8);  tick();
      exp_beat("t1_b2", 64'd11); tick();
      exp_beat("t1_b3", 64'd14); tick();
      exp_eos("t1_eos");         tick();
      exp_done("t1_done");       tick();
      exp_idle("t1_idle");

      // 2: count 0 goes straight to EOS
      start(64'd9, 64'd9, 32'd0);
      exp_eos("t2_eos");         tick();
      exp_done("t2_done");       tick();
      exp_idle("t2_idle");

      // 3: wrap through 2^64
      start(64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 32'd3);
      exp_beat("t3_b0", 64'hFFFF_FFFF_FFFF_FFFE); tick();
      exp_beat("t3_b1", 64'hFFFF_FFFF_FFFF_FFFF); tick();
      exp_beat("t3_b2", 64'd0);                   tick();
      exp_eos("t3_eos");                          tick();
      exp_done("t3_done");                        tick();
      exp_idle("t3_idle");

      // 4: out0_ready pattern 1,0,0 repeating
      start(64'd0, 64'd1, 32'd5);
      idx = 0;
      for (int unsigned c = 0; c < 40 && idx < 6; c++) begin
         if (idx < 5) exp_beat($sformatf("t4_b%0d", idx), 64'(idx));
         else         exp_eos("t4_eos");
         r = (c % 3 == 0);
         bus.out0_ready = r;
         tick();
         if (r) idx++;
      end
      chk("t4_beats", 64'(idx), 64'd6);
      bus.out0_ready = 1'b1;
      exp_done("t4_done");       tick();
      exp_idle("t4_idle");

      // 5: start token held during a run; completion back-pressured
      bus.outCtrl_ready = 1'b0;
      bus.inCtrl_valid  = 1'b1;
      bus.cfg_start     = 64'd10;
      bus.cfg_step      = 64'd2;
      bus.cfg_count     = 32'd3;
      tick();
      bus.cfg_start = 64'd100;
      bus.cfg_step  = 64'd7;
      bus.cfg_count = 32'd2;
      exp_beat("t5_b0", 64'd10);
      chk("t5_busy_rdy", 64'(bus.inCtrl_ready), 64'd0); tick();
      exp_beat("t5_b1", 64'd12); tick();
      exp_beat("t5_b2", 64'd14); tick();
      exp_eos("t5_eos");         tick();
      exp_done("t5_done0");      tick();
      exp_done("t5_done1");
      bus.outCtrl_ready = 1'b1;
      tick();
      exp_idle("t5_idle");
      tick();
      bus.inCtrl_valid = 1'b0;
      exp_beat("t5_r2b0", 64'd100); tick();
      exp_beat("t5_r2b1", 64'd107); tick();
      exp_eos("t5_r2eos");          tick();
      exp_done("t5_r2done");        tick();
      exp_idle("t5_r2idle");

      // 6: reset in the middle of a run
      start(64'h40, 64'd1, 32'd10);
      exp_beat("t6_b0", 64'h40); tick();
      exp_beat("t6_b1", 64'h41); tick();
      exp_beat("t6_b2", 64'h42);
      rst = 1'b1;
      #1;
      chk("t6_rst_out0",  64'(bus.out0_valid), 64'd0);
      chk("t6_rst_inrdy", 64'(bus.inCtrl_ready), 64'd0);
      chk("t6_rst_ctrl",  64'(bus.outCtrl_valid), 64'd0);
      tick();
      rst = 1'b0;
      #1;
      exp_idle("t6_post");
      for (int unsigned i = 0; i < 3; i++) begin
         tick();
         exp_idle($sformatf("t6_quiet%0d", i));
      end
      start(64'd7, 64'd5, 32'd2);
      exp_beat("t6_n0", 64'd7);  tick();
      exp_beat("t6_n1", 64'd12); tick();
      exp_eos("t6_neos");        tick();
      exp_done("t6_ndone");      tick();
      exp_idle("t6_nidle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
